// File: rtl/match_event_reporter_pkg.sv
// Shared encodings for the match event reporter: FSM states, report header
// tag and the field layout of the configuration word.
package match_event_reporter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_QUALIFY  = 3'd1,
        ST_EMIT_HDR = 3'd2,
        ST_EMIT_TS  = 3'd3,
        ST_HOLDOFF  = 3'd4
    } state_t;

    localparam logic [7:0] HDR_TAG = 8'hA5;

    localparam int CFG_ENABLE_BIT  = 31;
    localparam int CFG_MIN_RUN_LSB = 16;
    localparam int CFG_MIN_RUN_W   = 3;
    localparam int CFG_HOLDOFF_LSB = 0;
    localparam int CFG_HOLDOFF_W   = 16;

    // First word of a report: tag, sequence number, run length that qualified.
    function automatic logic [31:0] make_header(input logic [7:0] seq, input logic [2:0] run);
        return {HDR_TAG, seq, 13'd0, run};
    endfunction

endpackage

// File: rtl/match_event_reporter_event_fifo.sv
// Small synchronous show-ahead FIFO holding report words. The head word is
// presented combinationally; it reads as zero while the FIFO is empty.
module event_fifo
    import match_event_reporter_pkg::*;
#(
    parameter int AW = 4,
    parameter int W  = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head_data,
    output logic [AW:0]   count,
    output logic          empty
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;

    assign empty     = (count == '0);
    assign do_pop    = pop & ~empty;
    assign head_data = empty ? '0 : mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks simultaneous push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/match_event_reporter.sv
// Debounces per-sample match decisions into detection events, timestamps
// each one with the rx sample count and queues a header/timestamp report pair.
module match_event_reporter
    import match_event_reporter_pkg::*;
#(
    parameter int FIFO_AW = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxstrobe,
    input  logic        valid,
    input  logic        match,
    input  logic        cfg_write,
    input  logic [31:0] cfg_data,
    output logic [31:0] report_data,
    output logic        report_valid,
    input  logic        report_ready,
    output logic [15:0] drop_count,
    output logic [15:0] debugbus
);

    localparam int DEPTH = 1 << FIFO_AW;

    state_t          state;
    logic [2:0]      run;
    logic [31:0]     ts;
    logic [31:0]     ts_lat;
    logic [7:0]      seq;
    logic [15:0]     hcnt;

    logic            enable;
    logic [2:0]      min_run;
    logic [15:0]     holdoff;

    logic            hit;
    logic            qualify;
    logic            room;
    logic            push;
    logic [31:0]     push_data;
    logic [FIFO_AW:0] fifo_count;
    logic            fifo_empty;
    logic [2:0]      cfg_min_run;
    logic            unused_cfg_bits;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign hit         = valid & match;
    assign cfg_min_run = cfg_data[CFG_MIN_RUN_LSB +: CFG_MIN_RUN_W];
    assign unused_cfg_bits = ^cfg_data[30:19];

    // A report pair is only started when both words are guaranteed to fit.
    assign room = (int'(fifo_count) <= DEPTH - 2);

    // Qualification decision taken on the edge of the final matching valid.
    always_comb begin
        qualify = 1'b0;
        case (state)
            ST_IDLE:    qualify = enable & hit & (min_run == 3'd1);
            ST_QUALIFY: qualify = enable & hit & ((run + 3'd1) == min_run);
            default:    qualify = 1'b0;
        endcase
    end

    // Configuration register; a zero run length behaves as one.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable  <= 1'b0;
            min_run <= 3'd1;
            holdoff <= '0;
        end else if (cfg_write) begin
            enable  <= cfg_data[CFG_ENABLE_BIT];
            min_run <= (cfg_min_run == 3'd0) ? 3'd1 : cfg_min_run;
            holdoff <= cfg_data[CFG_HOLDOFF_LSB +: CFG_HOLDOFF_W];
        end
    end

    // Free-running sample counter, independent of enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts <= '0;
        end else if (rxstrobe) begin
            ts <= ts + 32'd1;
        end
    end

    // Capture the pre-increment timestamp of the first match of a run.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && enable && hit) begin
            ts_lat <= ts;
        end
    end

    // Event FSM: qualify runs, emit atomic report pairs, then hold off.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            run        <= '0;
            seq        <= '0;
            hcnt       <= '0;
            drop_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable && hit) begin
                        run   <= 3'd1;
                        state <= ST_QUALIFY;
                    end
                end
                ST_QUALIFY: begin
                    if (!enable) begin
                        run   <= '0;
                        state <= ST_IDLE;
                    end else if (valid) begin
                        if (match) begin
                            run <= run + 3'd1;
                        end else begin
                            run   <= '0;
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_EMIT_HDR: begin
                    state <= ST_EMIT_TS;
                end
                ST_EMIT_TS: begin
                    seq   <= seq + 8'd1;
                    hcnt  <= '0;
                    state <= (holdoff == '0) ? ST_IDLE : ST_HOLDOFF;
                end
                ST_HOLDOFF: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (rxstrobe) begin
                        hcnt <= hcnt + 16'd1;
                        // >= rather than == so a holdoff shortened mid-window still exits
                        if ((hcnt + 16'd1) >= holdoff) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Overrides the per-state next state on the qualifying edge.
            if (qualify) begin
                if (room) begin
                    state <= ST_EMIT_HDR;
                end else begin
                    drop_count <= sat_inc16(drop_count);
                    seq        <= seq + 8'd1;
                    hcnt       <= '0;
                    // With no holdoff programmed a drop returns straight to IDLE.
                    state      <= (holdoff == '0) ? ST_IDLE : ST_HOLDOFF;
                end
            end
        end
    end

    assign push      = (state == ST_EMIT_HDR) || (state == ST_EMIT_TS);
    assign push_data = (state == ST_EMIT_HDR) ? make_header(seq, run) : ts_lat;

    event_fifo #(
        .AW (FIFO_AW),
        .W  (32)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (report_ready),
        .head_data (report_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign report_valid = ~fifo_empty;
    assign debugbus     = {3'(state), run, 5'(fifo_count), seq[4:0]};

endmodule
